// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer: state encoding and default widths.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   localparam int PC_W_DEF        = 64;
   localparam int INST_W_DEF      = 32;
   localparam int SB_W_DEF        = 8;
   localparam int BUBBLE_INST_DEF = 0;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready bus between two adjacent pipeline stages, as seen by one stage buffer.
interface pipe_stage_buf_if
   import pipe_pkg::*;
#(
   parameter int PC_W   = PC_W_DEF,
   parameter int INST_W = INST_W_DEF,
   parameter int SB_W   = SB_W_DEF
);

   logic              in_valid_i;
   logic              in_ready_o;
   logic [PC_W-1:0]   in_pc_i;
   logic [INST_W-1:0] in_inst_i;
   logic [SB_W-1:0]   in_sb_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [PC_W-1:0]   out_pc_o;
   logic [INST_W-1:0] out_inst_o;
   logic [SB_W-1:0]   out_sb_o;

   // master: the environment around the buffer (upstream producer + downstream consumer)
   modport master (
      output in_valid_i, in_pc_i, in_inst_i, in_sb_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_pc_o, out_inst_o, out_sb_o
   );

   modport slave (
      input  in_valid_i, in_pc_i, in_inst_i, in_sb_i, out_ready_i,
      output in_ready_o, out_valid_o, out_pc_o, out_inst_o, out_sb_o
   );

endinterface

// File: rtl/pipe_perf_cnt.sv
// 32-bit wrapping event counter, one increment per cycle with i_inc high.
module pipe_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_inc,
   output logic [31:0] o_cnt
);

   logic [31:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with a 2-entry skid buffer, flush and bubble output.
// Optional stall/flush counters are built when PIPE_STAGE_BUF_PERF_EN is defined.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int                PC_W        = PC_W_DEF,
   parameter int                INST_W      = INST_W_DEF,
   parameter int                SB_W        = SB_W_DEF,
   parameter logic [INST_W-1:0] BUBBLE_INST = INST_W'(BUBBLE_INST_DEF)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   pipe_stage_buf_if.slave stage
`ifdef PIPE_STAGE_BUF_PERF_EN
   ,
   output logic [31:0]     stall_cnt_o,
   output logic [31:0]     flush_cnt_o
`endif
);

   state_e            r_state;
   state_e            w_state_next;

   logic [PC_W-1:0]   r_main_pc;
   logic [INST_W-1:0] r_main_inst;
   logic [SB_W-1:0]   r_main_sb;
   logic [PC_W-1:0]   r_skid_pc;
   logic [INST_W-1:0] r_skid_inst;
   logic [SB_W-1:0]   r_skid_sb;

   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_main_from_in;
   logic              w_main_from_skid;
   logic              w_skid_from_in;

   // Ready depends on registered state only, so no combinational ready chain forms.
   assign w_in_ready  = (r_state != ST_FULL);
   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_in_fire   = stage.in_valid_i & w_in_ready;
   assign w_out_fire  = w_out_valid & stage.out_ready_i;

   always_comb begin
      w_state_next     = r_state;
      w_main_from_in   = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_state_next   = ST_HALF;
               w_main_from_in = 1'b1;
            end
         end
         ST_HALF: begin
            if (w_in_fire && w_out_fire) begin
               w_main_from_in = 1'b1;
            end else if (w_in_fire) begin
               w_state_next   = ST_FULL;
               w_skid_from_in = 1'b1;
            end else if (w_out_fire) begin
               w_state_next   = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_out_fire) begin
               w_state_next     = ST_HALF;
               w_main_from_skid = 1'b1;
            end
         end
         default: w_state_next = ST_EMPTY;
      endcase
      // Flush wins over any transfer; a beat accepted this cycle is dropped.
      if (flush_i) begin
         w_state_next     = ST_EMPTY;
         w_main_from_in   = 1'b0;
         w_main_from_skid = 1'b0;
         w_skid_from_in   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_pc   <= '0;
         r_main_inst <= '0;
         r_main_sb   <= '0;
         r_skid_pc   <= '0;
         r_skid_inst <= '0;
         r_skid_sb   <= '0;
      end else if (flush_i) begin
         r_main_pc   <= '0;
         r_main_inst <= '0;
         r_main_sb   <= '0;
         r_skid_pc   <= '0;
         r_skid_inst <= '0;
         r_skid_sb   <= '0;
      end else begin
         // Main PC is left untouched on drain so the last PC stays visible.
         if (w_main_from_in) begin
            r_main_pc   <= stage.in_pc_i;
            r_main_inst <= stage.in_inst_i;
            r_main_sb   <= stage.in_sb_i;
         end else if (w_main_from_skid) begin
            r_main_pc   <= r_skid_pc;
            r_main_inst <= r_skid_inst;
            r_main_sb   <= r_skid_sb;
         end
         if (w_skid_from_in) begin
            r_skid_pc   <= stage.in_pc_i;
            r_skid_inst <= stage.in_inst_i;
            r_skid_sb   <= stage.in_sb_i;
         end else if (w_main_from_skid) begin
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
            r_skid_sb   <= '0;
         end
      end
   end

   assign stage.in_ready_o  = w_in_ready;
   assign stage.out_valid_o = w_out_valid;
   assign stage.out_pc_o    = r_main_pc;
   assign stage.out_inst_o  = w_out_valid ? r_main_inst : BUBBLE_INST;
   assign stage.out_sb_o    = w_out_valid ? r_main_sb : '0;

`ifdef PIPE_STAGE_BUF_PERF_EN
   logic w_stall_evt;
   logic w_flush_evt;

   assign w_stall_evt = w_out_valid & ~stage.out_ready_i;
   assign w_flush_evt = flush_i & w_out_valid;

   pipe_perf_cnt u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_stall_evt),
      .o_cnt (stall_cnt_o)
   );

   pipe_perf_cnt u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_flush_evt),
      .o_cnt (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed phases plus a FIFO scoreboard on the output side.
module tb_pipe_stage_buf;
   import pipe_pkg::*;

   localparam int          PC_W   = 64;
   localparam int          INST_W = 32;
   localparam int          SB_W   = 8;
   localparam logic [31:0] TB_BUBBLE = 32'h0000_0013;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
      logic [SB_W-1:0]   sb;
   } beat_t;

   logic clk;
   logic rst_n;
   logic flush;

   beat_t       exp_q[$];
   int unsigned n_checks;
   int unsigned n_pass;

   logic            prev_stall;
   logic            prev_flush;
   logic [PC_W-1:0] prev_pc;
   logic [31:0]     prev_inst;
   logic [7:0]      prev_sb;

   pipe_stage_buf_if #(.PC_W(PC_W), .INST_W(INST_W), .SB_W(SB_W)) bus ();

`ifdef PIPE_STAGE_BUF_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   logic [31:0] base_stall;
   logic [31:0] base_flush;
`endif

   pipe_stage_buf #(
      .PC_W        (PC_W),
      .INST_W      (INST_W),
      .SB_W        (SB_W),
      .BUBBLE_INST (TB_BUBBLE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .stage       (bus)
`ifdef PIPE_STAGE_BUF_PERF_EN
      ,
      .stall_cnt_o (stall_cnt),
      .flush_cnt_o (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] mk_inst(input logic [63:0] pc);
      return pc[31:0] ^ 32'h1234_5678;
   endfunction

   function automatic logic [7:0] mk_sb(input logic [63:0] pc);
      return pc[9:2] ^ 8'h5A;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] pc);
      bus.in_valid_i = 1'b1;
      bus.in_pc_i    = pc;
      bus.in_inst_i  = mk_inst(pc);
      bus.in_sb_i    = mk_sb(pc);
   endtask

   // Scoreboard: handshakes are evaluated mid-cycle for the coming edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         prev_stall = 1'b0;
         prev_flush = 1'b0;
      end else begin
         if (!bus.out_valid_o) begin
            chk("bubble_inst", 64'(bus.out_inst_o), 64'(TB_BUBBLE));
            chk("bubble_sb", 64'(bus.out_sb_o), 64'd0);
         end
         if (prev_stall && !prev_flush) begin
            chk("stable_valid", 64'(bus.out_valid_o), 64'd1);
            chk("stable_pc", bus.out_pc_o, prev_pc);
            chk("stable_inst", 64'(bus.out_inst_o), 64'(prev_inst));
            chk("stable_sb", 64'(bus.out_sb_o), 64'(prev_sb));
         end
         if (bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out", 64'(exp_q.size()), 64'd1);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               $display("out beat pc=0x%0h inst=0x%0h sb=0x%0h", bus.out_pc_o, bus.out_inst_o, bus.out_sb_o);
               chk("order_pc", bus.out_pc_o, e.pc);
               chk("order_inst", 64'(bus.out_inst_o), 64'(e.inst));
               chk("order_sb", 64'(bus.out_sb_o), 64'(e.sb));
            end
         end
         if (flush) begin
            exp_q.delete();
         end else if (bus.in_valid_i && bus.in_ready_o) begin
            exp_q.push_back('{pc: bus.in_pc_i, inst: bus.in_inst_i, sb: bus.in_sb_i});
         end
         prev_stall = bus.out_valid_o & ~bus.out_ready_i;
         prev_flush = flush;
         prev_pc    = bus.out_pc_o;
         prev_inst  = bus.out_inst_o;
         prev_sb    = bus.out_sb_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      flush    = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.in_pc_i     = '0;
      bus.in_inst_i   = '0;
      bus.in_sb_i     = '0;
      bus.out_ready_i = 1'b0;

      #2;
      chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
      chk("rst_pc", bus.out_pc_o, 64'd0);
      chk("rst_inst", 64'(bus.out_inst_o), 64'(TB_BUBBLE));
      chk("rst_sb", 64'(bus.out_sb_o), 64'd0);
      #10 rst_n = 1'b1;
      tick();
      chk("rst_ready", 64'(bus.in_ready_o), 64'd1);

      // Streaming with downstream always ready.
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         logic [63:0] pc;
         pc = 64'h8000_0000 + 64'(4 * i);
         drive(pc);
         tick();
         chk("stream_lat_pc", bus.out_pc_o, pc);
         chk("stream_valid", 64'(bus.out_valid_o), 64'd1);
         chk("stream_ready", 64'(bus.in_ready_o), 64'd1);
      end
      bus.in_valid_i = 1'b0;
      tick();
      chk("drain_valid", 64'(bus.out_valid_o), 64'd0);
      chk("drain_pc_kept", bus.out_pc_o, 64'h8000_0008);

      // Back-pressure fills the skid entry.
      bus.out_ready_i = 1'b0;
      drive(64'h100);
      tick();
      chk("bp_half_ready", 64'(bus.in_ready_o), 64'd1);
      drive(64'h104);
      tick();
      chk("bp_full_ready", 64'(bus.in_ready_o), 64'd0);
      chk("bp_full_pc", bus.out_pc_o, 64'h100);
      bus.in_valid_i = 1'b0;
      tick();
      chk("bp_hold_pc", bus.out_pc_o, 64'h100);
      bus.out_ready_i = 1'b1;
      tick();
      chk("bp_ready_back", 64'(bus.in_ready_o), 64'd1);
      chk("bp_second_pc", bus.out_pc_o, 64'h104);
      tick();
      chk("bp_empty", 64'(bus.out_valid_o), 64'd0);

      // Flush while FULL with an input offered.
      bus.out_ready_i = 1'b0;
      drive(64'h200);
      tick();
      drive(64'h204);
      tick();
      drive(64'h208);
      flush = 1'b1;
      tick();
      chk("flfull_valid", 64'(bus.out_valid_o), 64'd0);
      chk("flfull_inst", 64'(bus.out_inst_o), 64'(TB_BUBBLE));
      chk("flfull_pc", bus.out_pc_o, 64'd0);
      chk("flfull_sb", 64'(bus.out_sb_o), 64'd0);
      chk("flfull_ready", 64'(bus.in_ready_o), 64'd1);
      flush = 1'b0;
      bus.in_valid_i = 1'b0;
      tick();
      chk("flfull_after", 64'(bus.out_valid_o), 64'd0);

      // Flush in HALF while a beat is accepted.
      drive(64'h300);
      tick();
      drive(64'h304);
      flush = 1'b1;
      tick();
      chk("flhalf_valid", 64'(bus.out_valid_o), 64'd0);
      chk("flhalf_pc", bus.out_pc_o, 64'd0);
      flush = 1'b0;
      bus.in_valid_i = 1'b0;
      tick();
      chk("flhalf_dropped", 64'(bus.out_valid_o), 64'd0);

      // Flush coinciding with a delivered beat.
      drive(64'h310);
      tick();
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      flush = 1'b1;
      tick();
      chk("flfire_valid", 64'(bus.out_valid_o), 64'd0);
      flush = 1'b0;

      // Ten cycles of simultaneous accept and deliver.
      drive(64'h400);
      tick();
      for (int i = 1; i <= 10; i++) begin
         logic [63:0] pc;
         pc = 64'h400 + 64'(4 * i);
         drive(pc);
         tick();
         chk("thru_pc", bus.out_pc_o, pc);
         chk("thru_ready", 64'(bus.in_ready_o), 64'd1);
      end
      bus.in_valid_i = 1'b0;
      tick();
      chk("thru_drain", 64'(bus.out_valid_o), 64'd0);

      // Asynchronous reset while FULL.
      bus.out_ready_i = 1'b0;
      drive(64'h500);
      tick();
      drive(64'h504);
      tick();
      bus.in_valid_i = 1'b0;
      chk("arst_pre_full", 64'(bus.in_ready_o), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.out_valid_o), 64'd0);
      chk("arst_pc", bus.out_pc_o, 64'd0);
      chk("arst_inst", 64'(bus.out_inst_o), 64'(TB_BUBBLE));
      #2 rst_n = 1'b1;
      tick();
      chk("arst_ready", 64'(bus.in_ready_o), 64'd1);
      chk("arst_empty", 64'(bus.out_valid_o), 64'd0);

`ifdef PIPE_STAGE_BUF_PERF_EN
      // Five stall cycles then two flush cycles, only the first seeing a held entry.
      bus.out_ready_i = 1'b0;
      drive(64'h600);
      tick();
      bus.in_valid_i = 1'b0;
      base_stall = stall_cnt;
      base_flush = flush_cnt;
      repeat (5) tick();
      flush = 1'b1;
      bus.out_ready_i = 1'b1;
      tick();
      tick();
      flush = 1'b0;
      tick();
      chk("perf_stall", 64'(stall_cnt - base_stall), 64'd5);
      chk("perf_flush", 64'(flush_cnt - base_flush), 64'd1);
`endif

      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      tick();
      tick();
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
